// File: rtl/sample_seq_ctrl_pkg.sv
// ============================================================================
// Module      : sample_seq_ctrl_pkg
// Description : Shared state encodings and constants for the sample sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sample_seq_ctrl_pkg;

  localparam logic [2:0] c_ST_IDLE        = 3'd0;
  localparam logic [2:0] c_ST_LOAD        = 3'd1;
  localparam logic [2:0] c_ST_WAIT_ROM    = 3'd2;
  localparam logic [2:0] c_ST_CAPTURE     = 3'd3;
  localparam logic [2:0] c_ST_WAIT_PERIOD = 3'd4;
  localparam logic [2:0] c_ST_INCR        = 3'd5;
  localparam logic [2:0] c_ST_DONE        = 3'd6;

  // A programmed period of zero still spends one cycle in WAIT_PERIOD.
  localparam int c_PERIOD_MIN = 1;

endpackage

`default_nettype wire

// File: rtl/sample_seq_ctrl_period_timer.sv
// ============================================================================
// Module      : period_timer
// Description : Down-counter timing the WAIT_PERIOD interval of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                enable,
  output logic                expired
);

  logic [PERIOD_W-1:0] r_cnt;

  // Loaded with (cycles - 1) so expiry is seen in the last cycle of the wait.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/sample_seq_ctrl.sv
// ============================================================================
// Module      : sample_seq_ctrl
// Description : Sample-sequencer controller stepping a ROM pointer through a
//               latched address window with capture strobes and period waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_seq_ctrl
  import sample_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PERIOD_W = 16,
  parameter int ROM_LAT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic [PERIOD_W-1:0] period,
  input  logic                loop_mode,
  input  logic                abort,
  output logic                busy,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                sample_capture,
  output logic                done
);

  localparam int         c_LAT_W      = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
  localparam logic [c_LAT_W-1:0] c_LAT_LOAD = (ROM_LAT > 0) ? c_LAT_W'(ROM_LAT - 1) : '0;
  localparam logic [2:0] c_AFTER_LOAD = (ROM_LAT == 0) ? c_ST_CAPTURE : c_ST_WAIT_ROM;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [ADDR_W-1:0]   r_start_addr;
  logic [ADDR_W-1:0]   r_end_addr;
  logic [PERIOD_W-1:0] r_period;
  logic                r_loop;
  logic                r_wrap;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [c_LAT_W-1:0]  r_lat_cnt;
  logic                w_accept;
  logic                w_abort;
  logic                w_period_exp;
  logic                w_at_end;
  logic [PERIOD_W-1:0] w_period_eff;

  assign w_accept     = (r_state == c_ST_IDLE) && start;
  assign w_abort      = (r_state != c_ST_IDLE) && abort;
  assign w_at_end     = (r_rom_addr == r_end_addr);
  assign w_period_eff = (period == '0) ? PERIOD_W'(c_PERIOD_MIN) : period;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:        if (start) w_next = c_ST_LOAD;
      c_ST_LOAD:        w_next = c_AFTER_LOAD;
      c_ST_WAIT_ROM:    if (r_lat_cnt == '0) w_next = c_ST_CAPTURE;
      c_ST_CAPTURE:     w_next = c_ST_WAIT_PERIOD;
      c_ST_WAIT_PERIOD: begin
        if (w_period_exp) begin
          w_next = (!w_at_end || r_loop) ? c_ST_INCR : c_ST_DONE;
        end
      end
      c_ST_INCR:        w_next = c_AFTER_LOAD;
      c_ST_DONE:        w_next = c_ST_IDLE;
      default:          w_next = c_ST_IDLE;
    endcase
    if (w_abort) begin
      w_next = c_ST_IDLE;
    end
  end

  always_comb begin
    busy           = (r_state != c_ST_IDLE);
    sample_capture = (r_state == c_ST_CAPTURE);
    done           = (r_state == c_ST_DONE);
  end

  assign rom_addr = r_rom_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_period     <= '0;
      r_loop       <= 1'b0;
    end else if (w_accept) begin
      r_start_addr <= start_addr;
      r_end_addr   <= end_addr;
      r_period     <= w_period_eff;
      r_loop       <= loop_mode;
    end
  end

  // The pointer only moves on accept and when INCR completes without abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_wrap     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rom_addr <= start_addr;
        r_wrap     <= 1'b0;
      end else if ((r_state == c_ST_INCR) && !w_abort) begin
        r_rom_addr <= r_wrap ? r_start_addr : r_rom_addr + 1'b1;
      end
      if ((r_state == c_ST_WAIT_PERIOD) && w_period_exp) begin
        r_wrap <= w_at_end && r_loop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat_cnt <= '0;
    end else if ((w_next == c_ST_WAIT_ROM) && (r_state != c_ST_WAIT_ROM)) begin
      r_lat_cnt <= c_LAT_LOAD;
    end else if ((r_state == c_ST_WAIT_ROM) && (r_lat_cnt != '0)) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_period_timer (
    .clk      (clk),
    .rst      (reset),
    .clear    (w_abort),
    .load     (r_state == c_ST_CAPTURE),
    .load_val (r_period - 1'b1),
    .enable   (r_state == c_ST_WAIT_PERIOD),
    .expired  (w_period_exp)
  );

endmodule

`default_nettype wire
